// File: rtl/sha_multi_operand_adder.sv
// Two-stage pipelined multi-operand adder: carry-save reduction into a register
// stage, then a clustered block-CLA final adder. Valid/ready on both sides.
module sha_multi_operand_adder #(
    parameter int WIDTH     = 32,
    parameter int NUM_OPS   = 5,
    parameter int CLA_BLOCK = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_OPS*WIDTH-1:0]   in_ops,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_sum,
    output logic                       out_ovf
);

    localparam int XW = $clog2(NUM_OPS);
    localparam int IW = WIDTH + XW;
    localparam int NG = (IW + CLA_BLOCK - 1) / CLA_BLOCK;
    localparam int TW = NG * CLA_BLOCK;

    // Handshake: a beat moves across a boundary on a cycle where the sender's
    // valid and the receiver's ready are both 1. Valid never waits for ready,
    // and a presented result stays stable until it is taken.
    logic s1_valid;
    logic s2_ready;
    logic [IW-1:0] s1_sum;
    logic [IW-1:0] s1_carry;

    assign s2_ready = !out_valid || out_ready;
    assign in_ready = rst_n && (!s1_valid || s2_ready);

    // Stage 1: 3:2 compressor chain folds each further operand into (sum, carry).
    logic [IW-1:0] csa_s;
    logic [IW-1:0] csa_c;

    always_comb begin
        logic [IW-1:0] op;
        logic [IW-1:0] maj;
        op    = '0;
        maj   = '0;
        csa_s = {{XW{1'b0}}, in_ops[0 +: WIDTH]};
        csa_c = {{XW{1'b0}}, in_ops[WIDTH +: WIDTH]};
        for (int k = 2; k < NUM_OPS; k++) begin
            op    = {{XW{1'b0}}, in_ops[k*WIDTH +: WIDTH]};
            maj   = (csa_s & csa_c) | (csa_s & op) | (csa_c & op);
            csa_s = csa_s ^ csa_c ^ op;
            csa_c = maj << 1;
        end
    end

    // Stage 2: block CLA, lookahead across groups inside a 4-group cluster,
    // ripple from one cluster to the next.
    logic [TW-1:0] a2;
    logic [TW-1:0] b2;
    logic [TW-1:0] g;
    logic [TW-1:0] p;
    logic [TW-1:0] c;
    logic [TW-1:0] res;
    logic [NG-1:0] gg;
    logic [NG-1:0] gp;
    logic [NG-1:0] gc;
    logic          cout;

    always_comb begin
        logic t;
        logic clin;
        a2 = '0;
        b2 = '0;
        a2[IW-1:0] = s1_sum;
        b2[IW-1:0] = s1_carry;
        g  = a2 & b2;
        p  = a2 ^ b2;
        gg = '0;
        gp = '0;
        gc = '0;
        c  = '0;
        t  = 1'b0;
        clin = 1'b0;
        for (int j = 0; j < NG; j++) begin
            t = 1'b0;
            gp[j] = 1'b1;
            for (int b = 0; b < CLA_BLOCK; b++) begin
                t     = g[j*CLA_BLOCK+b] | (p[j*CLA_BLOCK+b] & t);
                gp[j] = gp[j] & p[j*CLA_BLOCK+b];
            end
            gg[j] = t;
        end
        for (int j = 0; j < NG; j++) begin
            t = clin;
            for (int i = (j / 4) * 4; i < j; i++) begin
                t = gg[i] | (gp[i] & t);
            end
            gc[j] = t;
            if (j % 4 == 3) begin
                clin = gg[j] | (gp[j] & gc[j]);
            end
        end
        for (int j = 0; j < NG; j++) begin
            t = gc[j];
            for (int b = 0; b < CLA_BLOCK; b++) begin
                c[j*CLA_BLOCK+b] = t;
                t = g[j*CLA_BLOCK+b] | (p[j*CLA_BLOCK+b] & t);
            end
        end
        res  = p ^ c;
        cout = gg[NG-1] | (gp[NG-1] & gc[NG-1]);
    end

    // The full-precision sum always fits in IW bits, so cout never fires; it is
    // folded into the flag only so every carry of the adder has a consumer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_sum    <= '0;
            s1_carry  <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_sum   <= csa_s;
                    s1_carry <= csa_c;
                end
            end
            if (s2_ready) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_sum <= res[WIDTH-1:0];
                    out_ovf <= (|res[TW-1:WIDTH]) | cout;
                end
            end
        end
    end

endmodule

// File: doc/sha_multi_operand_adder.md
Name: sha_multi_operand_adder

Overview:
- Pipelined modulo-2^WIDTH adder that sums NUM_OPS operands in a single beat.
- Generalised successor to the fixed 2-operand 32-bit CLA adder. Built from a carry-save reduction tree followed by a block-CLA final adder.
- Serves the SHA-256 round datapath: T1 = h + Σ1 + Ch + K + W (5 operands), T2 and the e/a updates (2–3 operands), and the message-schedule W update (4 operands).
- Valid/ready handshake on both sides, so it drops into the round pipeline with backpressure.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of CLA_BLOCK.
- NUM_OPS, 5, number of operands per beat; legal range 2..8.
- CLA_BLOCK, 4, group size of the final carry-lookahead adder; each group produces G/P.
- XW, derived = $clog2(NUM_OPS), number of extra high-order bits carried internally for overflow detection.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  in_ops holds a valid beat
- in_ready  output  1  block accepts a beat this cycle
- in_ops  input  NUM_OPS*WIDTH  operand k at bits [k*WIDTH +: WIDTH]
- out_valid  output  1  out_sum/out_ovf valid
- out_ready  input  1  downstream accepts the result
- out_sum  output  WIDTH  sum of all operands mod 2^WIDTH
- out_ovf  output  1  1 when the full-precision sum is ≥ 2^WIDTH

Behaviour:
- Reset: on any clock edge with rst_n=0:
  - s1_valid, out_valid, out_sum, out_ovf and all stage registers clear to 0.
  - in_ready is 0 during reset, and 1 on the first cycle after rst_n returns high.
- Reset mid-operation discards all in-flight beats. No partial result is ever presented.
- Stage 1 (S1):
  - Carry-save tree (3:2 compressors) reduces NUM_OPS operands to a sum vector and a carry vector, each WIDTH+XW bits, zero-extended.
  - S1 registers these vectors plus s1_valid.
- Stage 2 (S2):
  - Block-CLA adds the S1 vectors, WIDTH+XW bits, carry-in 0.
  - CLA groups are CLA_BLOCK bits. Group carries are lookahead across each 4-group cluster and ripple between clusters.
  - out_sum = result[WIDTH-1:0].
  - out_ovf = |result[WIDTH+XW-1:WIDTH].
  - S2 registers these with out_valid.
- Latency: exactly 2 cycles from accepted beat to out_valid when there is no backpressure. Throughput: 1 beat/cycle.
- Flow control:
  - s2_ready = !out_valid || out_ready
  - in_ready = !s1_valid || s2_ready
  - Accept when in_valid && in_ready.
  - S1 → S2 transfer when s1_valid && s2_ready.
- Output hold: while out_valid=1 and out_ready=0, out_sum/out_ovf are held stable and S2 does not change.
- Bubbles: a bubble in S1 is overwritten. The pipeline never holds more than 2 beats.
- Simultaneous events: accept + transfer + output handshake in the same cycle all take effect. Data order is strictly FIFO.
- in_ready depends combinationally on out_ready only; there is no path from in_valid to in_ready.
- in_ops is ignored when in_valid=0. Stage registers load only on a transfer, so there is no X propagation from idle inputs.
- Arithmetic:
  - Unsigned. Wrap-around mod 2^WIDTH is the normal result.
  - out_ovf is informational only; SHA datapaths ignore it.
  - XW bits are sufficient because NUM_OPS*(2^WIDTH-1) < 2^(WIDTH+XW).

Test Plan:
1. WIDTH=32, NUM_OPS=5. Ops {0x6a09e667, 0xbb67ae85, 0, 0, 0}, out_ready=1 → 2 cycles later out_sum=0x257194EC, out_ovf=1.
2. All five ops = 0xFFFFFFFF → out_sum=0xFFFFFFFB, out_ovf=1. All ops = 0 → out_sum=0, out_ovf=0.
3. 8 back-to-back beats; beat i has ops {i, i, i, i, i}, out_ready=1 → out_valid high on cycles 2..9, out_sum=5*i in order, in_ready stays 1.
4. Backpressure: out_ready=0 from cycle 0 while in_valid=1 with distinct beats → in_ready drops after 2 beats are accepted and out_sum holds the first result. Raise out_ready → the remaining results drain in order with no loss or duplication.
5. Reset mid-flight: both stages full, drive rst_n=0 for 1 cycle → out_valid=0 and out_sum=0 on the next edge. The next accepted beat yields a correct result 2 cycles later.
6. Random regression, NUM_OPS ∈ {2,3,4,8}, WIDTH ∈ {8,32}, random in_valid/out_ready → scoreboard compares against the full-precision reference sum (mod 2^WIDTH and the ≥2^WIDTH flag).
